// File: rtl/hvac_actuator.sv
// HVAC actuator sequencer: fan pre-run, minimum on, fan post-run and lockout timing
// for heater/compressor. Optional conflict fault detection under HVAC_FAULT_EN.
module hvac_actuator #(
    parameter int CNT_W     = 8,
    parameter int FAN_PRE   = 4,
    parameter int MIN_ON    = 20,
    parameter int FAN_POST  = 6,
    parameter int MIN_OFF   = 10,
    parameter int FAULT_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heating,
    input  logic       cooling,
    output logic       heater_on,
    output logic       compressor_on,
    output logic       fan_on,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_HEAT    = 3'd2,
        ST_COOL    = 3'd3,
        ST_POST    = 3'd4,
        ST_LOCKOUT = 3'd5,
        ST_FAULT   = 3'd6,
        ST_UNUSED  = 3'd7
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(FAN_PRE - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(FAN_POST - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF - 1);
    localparam int               CNT_MAX   = (1 << CNT_W) - 1;

    // Elaboration-time range checks on the timing parameters
    if (FAN_PRE < 1 || FAN_PRE > CNT_MAX) begin : g_chk_pre
        $error("hvac_actuator: FAN_PRE out of range");
    end
    if (MIN_ON < 1 || MIN_ON > CNT_MAX) begin : g_chk_on
        $error("hvac_actuator: MIN_ON out of range");
    end
    if (FAN_POST < 1 || FAN_POST > CNT_MAX) begin : g_chk_post
        $error("hvac_actuator: FAN_POST out of range");
    end
    if (MIN_OFF < 1 || MIN_OFF > CNT_MAX) begin : g_chk_off
        $error("hvac_actuator: MIN_OFF out of range");
    end
    if (FAULT_CYC < 1 || FAULT_CYC > CNT_MAX) begin : g_chk_fault
        $error("hvac_actuator: FAULT_CYC out of range");
    end

    // Output bit order {heater, compressor, fan}; decoded from the state only.
    function automatic logic [2:0] decode_outs(input state_e s);
        logic [2:0] o;
        case (s)
            ST_PRE:  o = 3'b001;
            ST_HEAT: o = 3'b101;
            ST_COOL: o = 3'b011;
            ST_POST: o = 3'b001;
            default: o = 3'b000;
        endcase
        return o;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;   // 1'b0 = heat, 1'b1 = cool
    logic             heater_q, compressor_q, fan_q;
    logic [2:0]       outs_d;
    logic             heat_req_s, cool_req_s, mode_req_s;

    assign heat_req_s = heating & ~cooling;
    assign cool_req_s = cooling & ~heating;
    assign mode_req_s = mode_q ? cool_req_s : heat_req_s;

`ifdef HVAC_FAULT_EN
    localparam logic [CNT_W-1:0] FAULT_LIM = CNT_W'(FAULT_CYC);
    logic [CNT_W-1:0] conf_q, conf_d;
    logic             fault_q;

    // Saturating count of consecutive heating&cooling conflict cycles
    always_comb begin
        conf_d = CNT_ZERO;
        if (heating & cooling) begin
            if (conf_q >= FAULT_LIM) begin
                conf_d = conf_q;
            end else begin
                conf_d = conf_q + CNT_ONE;
            end
        end else begin
            conf_d = CNT_ZERO;
        end
    end

    // Conflict counter and latched fault flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conf_q  <= CNT_ZERO;
            fault_q <= 1'b0;
        end else begin
            conf_q  <= conf_d;
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Next-state, counter and mode logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (heat_req_s) begin
                    state_d = ST_PRE;
                    mode_d  = 1'b0;
                end else if (cool_req_s) begin
                    state_d = ST_PRE;
                    mode_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (!mode_req_s) begin
                    state_d = ST_POST;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == PRE_LAST) begin
                    state_d = mode_q ? ST_COOL : ST_HEAT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HEAT, ST_COOL: begin
                // cnt_q counts edges already spent here, so MIN_ON is met at ON_LAST
                if (!mode_req_s && (cnt_q >= ON_LAST)) begin
                    state_d = ST_POST;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q >= ON_LAST) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_POST: begin
                if (cnt_q == POST_LAST) begin
                    state_d = ST_LOCKOUT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LOCKOUT: begin
                if (cnt_q == OFF_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef HVAC_FAULT_EN
            ST_FAULT: begin
                state_d = ST_FAULT;
                cnt_d   = CNT_ZERO;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
`ifdef HVAC_FAULT_EN
        if (conf_q >= FAULT_LIM) begin
            state_d = ST_FAULT;
            cnt_d   = CNT_ZERO;
        end else begin
            state_d = state_d;
        end
`endif
        outs_d = decode_outs(state_d);
    end

    // State, counter and registered actuator drives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            mode_q       <= 1'b0;
            heater_q     <= 1'b0;
            compressor_q <= 1'b0;
            fan_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            heater_q     <= outs_d[2];
            compressor_q <= outs_d[1];
            fan_q        <= outs_d[0];
        end
    end

    assign heater_on     = heater_q;
    assign compressor_on = compressor_q;
    assign fan_on        = fan_q;
    assign state         = state_q;

endmodule

// File: tb/tb_hvac_actuator.sv
// Directed self-checking bench for hvac_actuator (default parameters).
// Conflict expectations follow HVAC_FAULT_EN when it is defined.
module tb_hvac_actuator;

    logic       clk;
    logic       rst;
    logic       heating;
    logic       cooling;
    logic       heater_on;
    logic       compressor_on;
    logic       fan_on;
    logic [2:0] state;
    logic       fault;

    int pass_cnt;
    int total_cnt;

    hvac_actuator dut (
        .clk           (clk),
        .rst           (rst),
        .heating       (heating),
        .cooling       (cooling),
        .heater_on     (heater_on),
        .compressor_on (compressor_on),
        .fan_on        (fan_on),
        .state         (state),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {heater, compressor, fan} for a state code
    function automatic logic [2:0] exp_outs(input logic [2:0] s);
        case (s)
            3'd1:    return 3'b001;
            3'd2:    return 3'b101;
            3'd3:    return 3'b011;
            3'd4:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        heating = 1'b0;
        cooling = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({state, heater_on, compressor_on, fan_on, fault} !== 7'b0) begin
            $display("FAIL reset_state: got state=%0d h/c/f=%b%b%b fault=%b, expected all 0",
                     state, heater_on, compressor_on, fan_on, fault);
        end else begin
            pass_cnt++;
        end
        rst = 1'b0;
        tick();
        total_cnt++;
        if (state !== 3'd0) begin
            $display("FAIL reset_idle_hold: got state=%0d, expected 0", state);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_heat_cycle();
        logic [2:0] exp_s;
        do_reset();
        for (int e = 1; e <= 57; e++) begin
            heating = (e < 40);
            tick();
            exp_s = (e <= 4) ? 3'd1 : (e <= 39) ? 3'd2 : (e <= 45) ? 3'd4 :
                    (e <= 55) ? 3'd5 : 3'd0;
            total_cnt++;
            if ({state, heater_on, compressor_on, fan_on} !== {exp_s, exp_outs(exp_s)}) begin
                $display("FAIL heat_cycle edge %0d: got state=%0d h/c/f=%b%b%b, expected state=%0d h/c/f=%b",
                         e, state, heater_on, compressor_on, fan_on, exp_s, exp_outs(exp_s));
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_min_on_pulse();
        logic [2:0] exp_s;
        int         heat_cycles;
        heat_cycles = 0;
        do_reset();
        for (int e = 1; e <= 42; e++) begin
            heating = (e <= 8);
            tick();
            if (heater_on === 1'b1) heat_cycles++;
            exp_s = (e <= 4) ? 3'd1 : (e <= 24) ? 3'd2 : (e <= 30) ? 3'd4 :
                    (e <= 40) ? 3'd5 : 3'd0;
            total_cnt++;
            if ({state, heater_on, compressor_on, fan_on} !== {exp_s, exp_outs(exp_s)}) begin
                $display("FAIL min_on edge %0d: got state=%0d h/c/f=%b%b%b, expected state=%0d h/c/f=%b",
                         e, state, heater_on, compressor_on, fan_on, exp_s, exp_outs(exp_s));
            end else begin
                pass_cnt++;
            end
        end
        total_cnt++;
        if (heat_cycles !== 20) begin
            $display("FAIL min_on_length: got %0d heater cycles, expected 20", heat_cycles);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_lockout_ignore();
        logic [2:0] exp_s;
        do_reset();
        for (int e = 1; e <= 26; e++) begin
            heating = (e == 1);
            cooling = (e >= 10);
            tick();
            exp_s = (e == 1) ? 3'd1 : (e <= 7) ? 3'd4 : (e <= 17) ? 3'd5 :
                    (e == 18) ? 3'd0 : (e <= 22) ? 3'd1 : 3'd3;
            total_cnt++;
            if ({state, heater_on, compressor_on, fan_on} !== {exp_s, exp_outs(exp_s)}) begin
                $display("FAIL lockout edge %0d: got state=%0d h/c/f=%b%b%b, expected state=%0d h/c/f=%b",
                         e, state, heater_on, compressor_on, fan_on, exp_s, exp_outs(exp_s));
            end else begin
                pass_cnt++;
            end
        end
        cooling = 1'b0;
    endtask

    task automatic test_pre_abort();
        logic [2:0] exp_s;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            heating = (e <= 2);
            tick();
            exp_s = (e <= 2) ? 3'd1 : (e <= 8) ? 3'd4 : (e <= 18) ? 3'd5 : 3'd0;
            total_cnt++;
            if ({state, heater_on, compressor_on, fan_on} !== {exp_s, exp_outs(exp_s)}) begin
                $display("FAIL pre_abort edge %0d: got state=%0d h/c/f=%b%b%b, expected state=%0d h/c/f=%b",
                         e, state, heater_on, compressor_on, fan_on, exp_s, exp_outs(exp_s));
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_heat();
        do_reset();
        heating = 1'b1;
        repeat (10) tick();
        total_cnt++;
        if ({state, heater_on, fan_on} !== {3'd2, 1'b1, 1'b1}) begin
            $display("FAIL mid_heat_pre: got state=%0d heater=%b fan=%b, expected state=2 heater=1 fan=1",
                     state, heater_on, fan_on);
        end else begin
            pass_cnt++;
        end
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({state, heater_on, compressor_on, fan_on, fault} !== 7'b0) begin
            $display("FAIL async_reset: got state=%0d h/c/f=%b%b%b fault=%b, expected all 0",
                     state, heater_on, compressor_on, fan_on, fault);
        end else begin
            pass_cnt++;
        end
        heating = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        total_cnt++;
        if ({state, fan_on} !== {3'd0, 1'b0}) begin
            $display("FAIL after_reset_idle: got state=%0d fan=%b, expected state=0 fan=0", state, fan_on);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_conflict();
        logic [2:0] exp_s;
        logic       exp_f;
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            heating = (e <= 8);
            cooling = (e <= 8);
            tick();
`ifdef HVAC_FAULT_EN
            exp_s = (e <= 8) ? 3'd0 : 3'd6;
            exp_f = (e > 8);
`else
            exp_s = 3'd0;
            exp_f = 1'b0;
`endif
            total_cnt++;
            if ({state, heater_on, compressor_on, fan_on, fault} !== {exp_s, 3'b000, exp_f}) begin
                $display("FAIL conflict edge %0d: got state=%0d h/c/f=%b%b%b fault=%b, expected state=%0d h/c/f=000 fault=%b",
                         e, state, heater_on, compressor_on, fan_on, fault, exp_s, exp_f);
            end else begin
                pass_cnt++;
            end
        end
        heating = 1'b1;
        cooling = 1'b0;
        tick();
`ifdef HVAC_FAULT_EN
        exp_s = 3'd6;
`else
        exp_s = 3'd1;
`endif
        total_cnt++;
        if (state !== exp_s) begin
            $display("FAIL conflict_after: got state=%0d, expected %0d", state, exp_s);
        end else begin
            pass_cnt++;
        end
        heating = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        heating   = 1'b0;
        cooling   = 1'b0;
        test_reset();
        test_heat_cycle();
        test_min_on_pulse();
        test_lockout_ignore();
        test_pre_abort();
        test_reset_mid_heat();
        test_conflict();
        test_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
